// File: rtl/i2c_ext_pkg.sv
// Shared types and defaults for the I2C channel-routing controller and related bus stages.
// Holds the controller FSM state encoding plus default address and channel count.
package i2c_ext_pkg;

    localparam logic [6:0] CTRL_ADDR_DEF = 7'h70;
    localparam int         NUM_CH_DEF    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/i2c_route_ctrl_if.sv
// Upstream I2C pins plus the channel-select outputs of the routing controller.
// The slave modport is the controller's view; the master modport is the bus/fan-out side.
interface i2c_route_ctrl_if
    import i2c_ext_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF
);
    logic              scl_in;
    logic              sda_in;
    logic              sda_oe;
    logic [NUM_CH-1:0] chan_sel;
    logic              sel_valid;
    logic              busy;

    modport master (
        output scl_in, sda_in,
        input  sda_oe, chan_sel, sel_valid, busy
    );

    modport slave (
        input  scl_in, sda_in,
        output sda_oe, chan_sel, sel_valid, busy
    );
endinterface

// File: rtl/i2c_cond_detect.sv
// Synchronizes SCL/SDA and flags SCL edges and START/STOP; all flags are registered, 3 clk after the pin edge.
// Pure observer of the bus: no backpressure, every flag is a single-cycle pulse.
module i2c_cond_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);
    // [0],[1] form the synchronizer; [2] is the edge-detect history stage
    logic [2:0] r_scl_sync;
    logic [2:0] r_sda_sync;
    logic       r_scl_rise;
    logic       r_scl_fall;
    logic       r_start;
    logic       r_stop;

    logic w_scl_hi;
    assign w_scl_hi = r_scl_sync[1] & r_scl_sync[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_sync <= 3'b111;
            r_sda_sync <= 3'b111;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_scl_sync <= {r_scl_sync[1:0], i_scl};
            r_sda_sync <= {r_sda_sync[1:0], i_sda};
            r_scl_rise <= r_scl_sync[1] & ~r_scl_sync[2];
            r_scl_fall <= ~r_scl_sync[1] & r_scl_sync[2];
            r_start    <= w_scl_hi & ~r_sda_sync[1] & r_sda_sync[2];
            r_stop     <= w_scl_hi & r_sda_sync[1] & ~r_sda_sync[2];
        end
    end

    assign o_sda      = r_sda_sync[2];
    assign o_scl_rise = r_scl_rise;
    assign o_scl_fall = r_scl_fall;
    assign o_start    = r_start;
    assign o_stop     = r_stop;
endmodule

// File: rtl/i2c_route_ctrl.sv
// I2C slave that latches a written byte as the downstream channel mask; mask applies 1 clk after STOP/Sr.
// No backpressure (I2C ACK only). Define I2C_ROUTE_READBACK_EN to allow reading chan_sel back.
module i2c_route_ctrl
    import i2c_ext_pkg::*;
#(
    parameter logic [6:0] CTRL_ADDR = CTRL_ADDR_DEF,
    parameter int         NUM_CH    = NUM_CH_DEF
)(
    input  logic            clk,
    input  logic            rst,
    i2c_route_ctrl_if.slave bus
);
    logic w_sda, w_rise, w_fall, w_start, w_stop;

    i2c_cond_detect u_cond (
        .clk        (clk),
        .rst        (rst),
        .i_scl      (bus.scl_in),
        .i_sda      (bus.sda_in),
        .o_sda      (w_sda),
        .o_scl_rise (w_rise),
        .o_scl_fall (w_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_cnt, w_cnt_nxt;
    logic [7:0]        r_shift, w_shift_nxt;
    logic              r_byte_done, w_byte_done_nxt;
    logic              r_oe, w_oe_nxt;
    logic [NUM_CH-1:0] r_stage, w_stage_nxt;
    logic              r_data_done, w_data_done_nxt;
    logic [NUM_CH-1:0] r_chan_sel, w_chan_sel_nxt;
    logic              r_sel_valid, w_sel_valid_nxt;
    logic              r_busy, w_busy_nxt;
    logic              w_addr_ok;

`ifdef I2C_ROUTE_READBACK_EN
    logic       r_rw, w_rw_nxt;
    logic [7:0] r_tx, w_tx_nxt;
    logic [7:0] w_tx_load;
    assign w_tx_load = 8'(r_chan_sel);
    assign w_addr_ok = (r_shift[7:1] == CTRL_ADDR);
`else
    assign w_addr_ok = (r_shift[7:1] == CTRL_ADDR) && !r_shift[0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_byte_done <= 1'b0;
            r_oe        <= 1'b0;
            r_stage     <= '0;
            r_data_done <= 1'b0;
            r_chan_sel  <= '0;
            r_sel_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef I2C_ROUTE_READBACK_EN
            r_rw        <= 1'b0;
            r_tx        <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_byte_done <= w_byte_done_nxt;
            r_oe        <= w_oe_nxt;
            r_stage     <= w_stage_nxt;
            r_data_done <= w_data_done_nxt;
            r_chan_sel  <= w_chan_sel_nxt;
            r_sel_valid <= w_sel_valid_nxt;
            r_busy      <= w_busy_nxt;
`ifdef I2C_ROUTE_READBACK_EN
            r_rw        <= w_rw_nxt;
            r_tx        <= w_tx_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_shift_nxt     = r_shift;
        w_byte_done_nxt = r_byte_done;
        w_oe_nxt        = r_oe;
        w_stage_nxt     = r_stage;
        w_data_done_nxt = r_data_done;
        w_chan_sel_nxt  = r_chan_sel;
        w_sel_valid_nxt = 1'b0;
        w_busy_nxt      = r_busy;
`ifdef I2C_ROUTE_READBACK_EN
        w_rw_nxt        = r_rw;
        w_tx_nxt        = r_tx;
`endif
        if (w_start || w_stop) begin
            // Commit only whole bytes; a partial byte never reached r_stage
            if (r_data_done) begin
                w_chan_sel_nxt  = r_stage;
                w_sel_valid_nxt = 1'b1;
            end
            w_data_done_nxt = 1'b0;
            w_cnt_nxt       = '0;
            w_byte_done_nxt = 1'b0;
            w_oe_nxt        = 1'b0;
            w_state_nxt     = w_start ? ST_ADDR : ST_IDLE;
            w_busy_nxt      = w_start;
        end else begin
            case (r_state)
                ST_ADDR, ST_WDATA: begin
                    if (w_rise) begin
                        w_shift_nxt     = {r_shift[6:0], w_sda};
                        w_cnt_nxt       = r_cnt + 3'd1;
                        w_byte_done_nxt = (r_cnt == 3'd7);
                    end else if (w_fall && r_byte_done) begin
                        w_byte_done_nxt = 1'b0;
                        if (r_state == ST_WDATA) begin
                            w_state_nxt     = ST_WDATA_ACK;
                            w_oe_nxt        = 1'b1;
                            w_stage_nxt     = NUM_CH'(r_shift);
                            w_data_done_nxt = 1'b1;
                        end else if (w_addr_ok) begin
                            w_state_nxt = ST_ADDR_ACK;
                            w_oe_nxt    = 1'b1;
`ifdef I2C_ROUTE_READBACK_EN
                            w_rw_nxt    = r_shift[0];
`endif
                        end else begin
                            w_state_nxt = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_fall) begin
                        w_oe_nxt    = 1'b0;
                        w_state_nxt = ST_WDATA;
`ifdef I2C_ROUTE_READBACK_EN
                        if (r_rw) begin
                            w_state_nxt = ST_RDATA;
                            w_tx_nxt    = w_tx_load;
                            w_oe_nxt    = ~w_tx_load[7];
                        end
`endif
                    end
                end
                ST_WDATA_ACK: begin
                    if (w_fall) begin
                        w_oe_nxt    = 1'b0;
                        w_state_nxt = ST_WDATA;
                    end
                end
`ifdef I2C_ROUTE_READBACK_EN
                ST_RDATA: begin
                    if (w_rise) begin
                        w_cnt_nxt       = r_cnt + 3'd1;
                        w_byte_done_nxt = (r_cnt == 3'd7);
                    end else if (w_fall) begin
                        if (r_byte_done) begin
                            w_byte_done_nxt = 1'b0;
                            w_oe_nxt        = 1'b0;
                            w_state_nxt     = ST_RDATA_ACK;
                        end else begin
                            // counter already points at the next bit, MSB first
                            w_oe_nxt = ~r_tx[~r_cnt];
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (w_rise) begin
                        w_shift_nxt = {r_shift[6:0], w_sda};
                    end else if (w_fall) begin
                        if (!r_shift[0]) begin
                            w_state_nxt = ST_RDATA;
                            w_oe_nxt    = ~r_tx[7];
                        end else begin
                            w_state_nxt = ST_IGNORE;
                        end
                    end
                end
`endif
                ST_IDLE, ST_IGNORE: begin
                    w_state_nxt = r_state;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sda_oe    = r_oe;
    assign bus.chan_sel  = r_chan_sel;
    assign bus.sel_valid = r_sel_valid;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_i2c_route_ctrl.sv
// Directed bench for i2c_route_ctrl: drives an I2C master on the upstream pins and checks
// ACKs, channel-mask commits, pulse timing, reset abort and read-back (when I2C_ROUTE_READBACK_EN).
module tb_i2c_route_ctrl;
    import i2c_ext_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_drv = 1'b1;
    logic sda_drv = 1'b1;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int n_valid = 0;
    int last_valid_cyc = 0;
    int oe_high = 0;
    int oe_viol = 0;
    logic prev_oe = 1'b0;

    int mark_cyc = 0;
    int v0 = 0;
    int oh0 = 0;
    logic ack;
    logic [7:0] rd;

    always #5 clk = ~clk;

    i2c_route_ctrl_if #(.NUM_CH(8)) bus();
    assign bus.scl_in = scl_drv;
    assign bus.sda_in = sda_drv & ~bus.sda_oe;

    i2c_route_ctrl #(.CTRL_ADDR(7'h70), .NUM_CH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: sel_valid pulses, SDA-drive cycles, and SDA-drive changes while SCL is high
    always @(negedge clk) begin
        if (bus.sel_valid === 1'b1) begin
            n_valid        <= n_valid + 1;
            last_valid_cyc <= cyc;
        end
        if (bus.sda_oe === 1'b1) oe_high <= oe_high + 1;
        if ((bus.sda_oe !== prev_oe) && scl_drv) oe_viol <= oe_viol + 1;
        prev_oe <= bus.sda_oe;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wt(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wt(10);
        scl_drv = 1'b1; wt(10);
        sda_drv = 1'b0; mark_cyc = cyc; wt(10);
        scl_drv = 1'b0; wt(10);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wt(10);
        scl_drv = 1'b1; wt(10);
        sda_drv = 1'b1; mark_cyc = cyc; wt(20);
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b;    wt(10);
        scl_drv = 1'b1; wt(20);
        scl_drv = 1'b0; wt(10);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic a);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        sda_drv = 1'b1; wt(10);
        scl_drv = 1'b1; wt(10);
        a = bus.sda_in; wt(10);
        scl_drv = 1'b0; wt(10);
    endtask

    task automatic read_byte(output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            sda_drv = 1'b1; wt(10);
            scl_drv = 1'b1; wt(10);
            d[i] = bus.sda_in; wt(10);
            scl_drv = 1'b0; wt(10);
        end
    endtask

    initial begin
        // reset state
        wt(3);
        chk("rst_chan_sel", 32'(bus.chan_sel), 32'h00);
        chk("rst_sda_oe", 32'(bus.sda_oe), 32'h0);
        chk("rst_sel_valid", 32'(bus.sel_valid), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        wt(5);

        // single write of 0x05
        v0 = n_valid;
        i2c_start();
        chk("wr05_busy_after_start", 32'(bus.busy), 32'h1);
        write_byte(8'hE0, ack);
        chk("wr05_addr_ack", 32'(ack), 32'h0);
        write_byte(8'h05, ack);
        chk("wr05_data_ack", 32'(ack), 32'h0);
        i2c_stop();
        chk("wr05_chan_sel", 32'(bus.chan_sel), 32'h05);
        chk("wr05_valid_count", 32'(n_valid - v0), 32'h1);
        chk("wr05_valid_delay", 32'(last_valid_cyc - mark_cyc), 32'd4);
        chk("wr05_busy_after_stop", 32'(bus.busy), 32'h0);

        // wrong address: never driven, mask untouched
        v0 = n_valid; oh0 = oe_high;
        i2c_start();
        write_byte(8'h90, ack);
        chk("badaddr_nack", 32'(ack), 32'h1);
        write_byte(8'hFF, ack);
        chk("badaddr_data_nack", 32'(ack), 32'h1);
        chk("badaddr_busy_mid", 32'(bus.busy), 32'h1);
        i2c_stop();
        chk("badaddr_no_oe", 32'(oe_high - oh0), 32'h0);
        chk("badaddr_chan_sel", 32'(bus.chan_sel), 32'h05);
        chk("badaddr_no_valid", 32'(n_valid - v0), 32'h0);
        chk("badaddr_busy_after", 32'(bus.busy), 32'h0);

        // two data bytes: last one wins, single pulse
        v0 = n_valid;
        i2c_start();
        write_byte(8'hE0, ack);
        write_byte(8'h01, ack);
        chk("two_b1_ack", 32'(ack), 32'h0);
        write_byte(8'h80, ack);
        chk("two_b2_ack", 32'(ack), 32'h0);
        i2c_stop();
        chk("two_chan_sel", 32'(bus.chan_sel), 32'h80);
        chk("two_valid_count", 32'(n_valid - v0), 32'h1);

        // repeated START commits the mask; the following empty write commits nothing
        i2c_start();
        write_byte(8'hE0, ack);
        write_byte(8'h11, ack);
        v0 = n_valid;
        i2c_start();
        chk("rs_chan_sel", 32'(bus.chan_sel), 32'h11);
        chk("rs_valid_count", 32'(n_valid - v0), 32'h1);
        chk("rs_valid_delay", 32'(last_valid_cyc - mark_cyc), 32'd4);
        chk("rs_busy", 32'(bus.busy), 32'h1);
        write_byte(8'hE0, ack);
        chk("rs_addr_ack", 32'(ack), 32'h0);
        i2c_stop();
        chk("rs_empty_no_valid", 32'(n_valid - v0), 32'h1);
        chk("rs_chan_sel_kept", 32'(bus.chan_sel), 32'h11);

        // partial byte cut by STOP is discarded
        v0 = n_valid;
        i2c_start();
        write_byte(8'hE0, ack);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_stop();
        chk("partial_chan_sel", 32'(bus.chan_sel), 32'h11);
        chk("partial_no_valid", 32'(n_valid - v0), 32'h0);

        // reset mid-byte aborts; bus ignored until the next START
        i2c_start();
        write_byte(8'hE0, ack);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        rst = 1'b1;
        wt(2);
        chk("midrst_chan_sel", 32'(bus.chan_sel), 32'h00);
        chk("midrst_oe", 32'(bus.sda_oe), 32'h0);
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        wt(3);
        chk("midrst_state_idle", 32'(dut.r_state), 32'(ST_IDLE));
        v0 = n_valid; oh0 = oe_high;
        for (int i = 0; i < 6; i++) send_bit(1'b0);
        chk("midrst_no_ack", 32'(oe_high - oh0), 32'h0);
        chk("midrst_busy_ignored", 32'(bus.busy), 32'h0);
        i2c_stop();
        chk("midrst_stop_no_valid", 32'(n_valid - v0), 32'h0);
        chk("midrst_chan_sel_after", 32'(bus.chan_sel), 32'h00);

        // read-back of the mask
        i2c_start();
        write_byte(8'hE0, ack);
        write_byte(8'h3C, ack);
        i2c_stop();
        chk("rb_setup_chan_sel", 32'(bus.chan_sel), 32'h3C);
        v0 = n_valid; oh0 = oe_high;
        i2c_start();
        write_byte(8'hE1, ack);
`ifdef I2C_ROUTE_READBACK_EN
        chk("rb_addr_ack", 32'(ack), 32'h0);
        read_byte(rd);
        chk("rb_data", 32'(rd), 32'h3C);
        send_bit(1'b1);
        i2c_stop();
        chk("rb_no_valid", 32'(n_valid - v0), 32'h0);
`else
        chk("rb_addr_nack", 32'(ack), 32'h1);
        read_byte(rd);
        chk("rb_released", 32'(rd), 32'hFF);
        i2c_stop();
        chk("rb_no_oe", 32'(oe_high - oh0), 32'h0);
`endif
        chk("rb_chan_sel_kept", 32'(bus.chan_sel), 32'h3C);
        chk("rb_busy_after", 32'(bus.busy), 32'h0);

        // SDA drive must never have moved while SCL was high
        chk("oe_change_while_scl_high", 32'(oe_viol), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
